// File: rtl/seg_scan_driver_if.sv
// Display bus between score logic and the scanner: segment patterns/enables/brightness in, pin drives out.
// No flow control; the source drives the inputs continuously and the scanner samples them once per slot.
interface seg_scan_driver_if #(
    parameter int DIGITS = 4,
    parameter int SEG_W  = 8
);
    localparam int IW = $clog2(DIGITS);

    logic [DIGITS*SEG_W-1:0] seg_data;
    logic [DIGITS-1:0]       digit_en;
    logic [3:0]              brightness;
    logic [DIGITS-1:0]       an_n;
    logic [SEG_W-1:0]        seg_n;
    logic [IW-1:0]           digit_idx;
    logic                    frame_tick;

    modport master (
        output seg_data, digit_en, brightness,
        input  an_n, seg_n, digit_idx, frame_tick
    );

    modport slave (
        input  seg_data, digit_en, brightness,
        output an_n, seg_n, digit_idx, frame_tick
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Self-timed N-digit 7-segment scanner with per-digit enable, 16-level PWM and dead time.
// Latency 1 cycle from prescaler state to pins; no backpressure, the scan free-runs.
module seg_scan_driver #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000,
    parameter int SEG_W   = 8,
    parameter int DEAD    = 2
) (
    input  logic              clk,
    input  logic              reset,
    seg_scan_driver_if.slave  bus
);
    localparam int PW    = $clog2(CLK_DIV);
    localparam int LW    = PW + 1;
    localparam int IW    = $clog2(DIGITS);
    localparam int SLICE = CLK_DIV / 16;

    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              en_q, en_d;
    logic [3:0]        bri_q, bri_d;
    logic [SEG_W-1:0]  pat_q, pat_d;
    logic [DIGITS-1:0] an_n_q, an_n_d;
    logic [SEG_W-1:0]  seg_n_q, seg_n_d;
    logic              frame_tick_q, frame_tick_d;

    logic [LW-1:0]     lim;
    logic [LW-1:0]     presc_w;
    logic              lit;

    always_comb begin
        presc_d      = (presc_q == P_LAST) ? '0 : presc_q + PW'(1);
        idx_d        = idx_q;
        if (presc_q == P_LAST) begin
            idx_d = (idx_q == I_LAST) ? '0 : idx_q + IW'(1);
        end

        // Slot parameters are captured once at slot start so mid-slot input changes never tear the display.
        en_d  = en_q;
        bri_d = bri_q;
        pat_d = pat_q;
        if (presc_q == '0) begin
            en_d  = bus.digit_en[idx_q];
            bri_d = bus.brightness;
            pat_d = bus.seg_data[idx_q*SEG_W +: SEG_W];
        end

        // At p=0 the latched values still belong to the previous slot, but DEAD>=1 keeps p=0 dark.
        presc_w = {1'b0, presc_q};
        lim     = (LW'(bri_q) + LW'(1)) * LW'(SLICE);
        lit     = en_q && (presc_w >= LW'(DEAD)) && (presc_w < lim);

        an_n_d       = lit ? ~(DIGITS'(1) << idx_q) : '1;
        seg_n_d      = lit ? pat_q : '1;
        frame_tick_d = (presc_q == P_LAST) && (idx_q == I_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            en_q         <= 1'b0;
            bri_q        <= '0;
            pat_q        <= '1;
            an_n_q       <= '1;
            seg_n_q      <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            en_q         <= en_d;
            bri_q        <= bri_d;
            pat_q        <= pat_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.an_n       = an_n_q;
    assign bus.seg_n      = seg_n_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: elapsed-cycle reference model, vector table, corner sequences, random soak.
module tb_seg_scan_driver;
    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 32;
    localparam int SEG_W   = 8;
    localparam int DEAD    = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg_scan_driver_if #(.DIGITS(DIGITS), .SEG_W(SEG_W)) bus ();

    seg_scan_driver #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SEG_W(SEG_W), .DEAD(DEAD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference state: cycles elapsed since reset release plus the values captured at slot start.
    int         n;
    logic       m_en;
    int         m_b;
    logic [7:0] m_pat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle n=%0d)", name, act, exp, n);
        end
    endtask

    task automatic tick();
        int         p, i;
        logic       lit;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        int         e_idx;
        logic       e_ft;
        if (reset) begin
            n = 0; m_en = 1'b0; m_b = 0; m_pat = 8'hFF;
            e_an = 4'hF; e_seg = 8'hFF; e_idx = 0; e_ft = 1'b0;
        end else begin
            p     = n % CLK_DIV;
            i     = (n / CLK_DIV) % DIGITS;
            lit   = m_en && (p >= DEAD) && (p < (m_b + 1) * (CLK_DIV / 16));
            e_an  = lit ? ~(4'b0001 << i) : 4'hF;
            e_seg = lit ? m_pat : 8'hFF;
            e_ft  = (p == CLK_DIV - 1) && (i == DIGITS - 1);
            if (p == 0) begin
                m_en  = bus.digit_en[i];
                m_b   = int'(bus.brightness);
                m_pat = bus.seg_data[i*SEG_W +: SEG_W];
            end
            n++;
            e_idx = (n / CLK_DIV) % DIGITS;
        end
        @(posedge clk);
        #1;
        check("an_n", 32'(bus.an_n), 32'(e_an));
        check("seg_n", 32'(bus.seg_n), 32'(e_seg));
        check("digit_idx", 32'(bus.digit_idx), 32'(e_idx));
        check("frame_tick", 32'(bus.frame_tick), 32'(e_ft));
        check("an_onecold", 32'($countones(~bus.an_n) <= 1), 32'd1);
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (n != target && guard < 2000) begin
            tick();
            guard++;
        end
        check("run_to_reached", 32'(n), 32'(target));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [31:0]     seg;
        logic [3:0]      en;
        logic [3:0]      bri;
        logic [3:0][7:0] lit;   // expected lit cycles per digit in one frame
    } vec_t;

    vec_t vecs[6];

    initial begin
        reset = 1'b1;
        bus.seg_data   = '0;
        bus.digit_en   = '0;
        bus.brightness = '0;
        n = 0; m_en = 1'b0; m_b = 0; m_pat = 8'hFF;

        vecs[0] = '{32'h003F065B, 4'b1111, 4'd15, {8'd30, 8'd30, 8'd30, 8'd30}};
        vecs[1] = '{32'h003F065B, 4'b1111, 4'd3,  {8'd6,  8'd6,  8'd6,  8'd6}};
        vecs[2] = '{32'h003F065B, 4'b1111, 4'd0,  {8'd0,  8'd0,  8'd0,  8'd0}};
        vecs[3] = '{32'h003F065B, 4'b1010, 4'd15, {8'd30, 8'd0,  8'd30, 8'd0}};
        vecs[4] = '{32'h12345678, 4'b1111, 4'd1,  {8'd2,  8'd2,  8'd2,  8'd2}};
        vecs[5] = '{32'hA5C33C5A, 4'b0110, 4'd7,  {8'd0,  8'd14, 8'd14, 8'd0}};

        // Reset state
        tick();
        check("reset_an_n", 32'(bus.an_n), 32'hF);
        check("reset_seg_n", 32'(bus.seg_n), 32'hFF);
        check("reset_idx", 32'(bus.digit_idx), 32'd0);
        check("reset_ft", 32'(bus.frame_tick), 32'd0);

        // Table: one full frame per vector, tallying lit cycles, slot lengths and frame ticks
        for (int v = 0; v < 6; v++) begin
            int lit_cnt[4];
            int idx_cnt[4];
            int ft_cnt;
            do_reset();
            bus.seg_data   = vecs[v].seg;
            bus.digit_en   = vecs[v].en;
            bus.brightness = vecs[v].bri;
            ft_cnt = 0;
            for (int d = 0; d < 4; d++) begin
                lit_cnt[d] = 0;
                idx_cnt[d] = 0;
            end
            for (int c = 0; c < DIGITS * CLK_DIV; c++) begin
                tick();
                for (int d = 0; d < 4; d++) begin
                    if (bus.an_n[d] == 1'b0) lit_cnt[d]++;
                end
                idx_cnt[bus.digit_idx]++;
                if (bus.frame_tick) ft_cnt++;
            end
            for (int d = 0; d < 4; d++) begin
                check($sformatf("vec%0d_lit_d%0d", v, d), 32'(lit_cnt[d]), 32'(vecs[v].lit[d]));
                check($sformatf("vec%0d_slot_d%0d", v, d), 32'(idx_cnt[d]), 32'(CLK_DIV));
            end
            check($sformatf("vec%0d_frame_ticks", v), 32'(ft_cnt), 32'd1);
        end

        // Mid-slot pattern change on digit 1 takes effect only on its next visit
        do_reset();
        bus.seg_data   = 32'h003F065B;
        bus.digit_en   = 4'b1111;
        bus.brightness = 4'd15;
        run_to(CLK_DIV + 10);
        bus.seg_data[15:8] = 8'h4F;
        run_to(CLK_DIV + 28);
        check("hold_old_an", 32'(bus.an_n), 32'hD);
        check("hold_old_pat", 32'(bus.seg_n), 32'h06);
        run_to(DIGITS * CLK_DIV + CLK_DIV + 11);
        check("new_pat_an", 32'(bus.an_n), 32'hD);
        check("new_pat", 32'(bus.seg_n), 32'h4F);

        // One-cycle reset at p=15 of slot 2, then a full-length slot 0
        run_to(DIGITS * CLK_DIV + 2 * CLK_DIV + 15);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_an_n", 32'(bus.an_n), 32'hF);
        check("midrst_seg_n", 32'(bus.seg_n), 32'hFF);
        check("midrst_idx", 32'(bus.digit_idx), 32'd0);
        check("midrst_ft", 32'(bus.frame_tick), 32'd0);
        for (int c = 0; c < CLK_DIV - 1; c++) tick();
        check("restart_idx_hold", 32'(bus.digit_idx), 32'd0);
        tick();
        check("restart_idx_adv", 32'(bus.digit_idx), 32'd1);

        // Random soak: inputs change at arbitrary points, occasional resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(19) == 0) begin
                bus.seg_data   = $urandom;
                bus.digit_en   = 4'($urandom);
                bus.brightness = 4'($urandom);
            end
            reset = ($urandom_range(599) == 0);
            tick();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised multiplexed 7-segment display driver. It generalises the fixed 2-to-4 one-cold digit select into a self-timed scanner for N digits.
- It owns a refresh prescaler and digit index, and emits an active-low one-cold anode vector plus that digit's active-low segment pattern.
- Adds per-digit enable, 16-level brightness (PWM within each slot) and anti-ghosting dead time.
- Sits between the game/score logic and the board's anode/segment pins.

Parameters:
- DIGITS, 4, number of digits scanned; legal 2..16.
- CLK_DIV, 50000, clock cycles per digit slot; must be a multiple of 16, at least 16.
- SEG_W, 8, segment bits per digit (a..g plus dp), active-low.
- DEAD, 2, blanked cycles at the start of each slot; legal 1..CLK_DIV-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- seg_data  in  DIGITS*SEG_W  active-low patterns; digit i occupies bits [i*SEG_W +: SEG_W].
- digit_en  in  DIGITS  1 = digit i may light; 0 = digit i blanked.
- brightness  in  4  duty level; 15 = full, 0 = off.
- an_n  out  DIGITS  active-low one-cold anode select; all ones = no digit driven.
- seg_n  out  SEG_W  active-low segments for the driven digit; all ones when blank.
- digit_idx  out  clog2(DIGITS)  index of the current slot.
- frame_tick  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset: at the first edge with reset=1:
  - prescaler=0, idx=0.
  - Latched enable=0, latched brightness=0, latched pattern = all ones.
  - an_n = all ones, seg_n = all ones, frame_tick=0, digit_idx=0.
- Reset held:
  - State stays at reset values while reset=1.
  - Asserting reset mid-slot or mid-frame aborts immediately; there is no partial-frame completion.
- Prescaler:
  - Counts 0..CLK_DIV-1, one step per clk.
  - On the edge where prescaler=CLK_DIV-1, it wraps to 0 and idx advances: idx+1, or 0 when idx=DIGITS-1.
- Latching:
  - On the edge where prescaler=0, latch digit_en[idx], brightness and seg_data slice idx.
  - These values stay fixed for the rest of the slot; input changes mid-slot take effect next slot.
- Lit window: with pre-edge prescaler p and LIM=(latched brightness+1)*(CLK_DIV/16), the slot is lit when latched enable=1 AND DEAD <= p < LIM.
- Registered outputs, updated each edge from pre-edge state:
  - Lit: an_n = all ones except bit idx=0; seg_n = latched pattern.
  - Not lit: an_n = all ones, seg_n = all ones.
  - an_n therefore always has zero or one bit low, never more.
- Output latency: one cycle behind the prescaler value it reflects.
- Brightness boundaries:
  - If LIM <= DEAD, the digit is dark the whole slot (e.g. brightness 0 with CLK_DIV=32, DEAD=2).
  - Brightness 15 gives lit cycles = CLK_DIV-DEAD.
- digit_idx: equals the registered idx. It changes on the same edge the prescaler wraps.
- frame_tick: 1 for exactly the one cycle following the edge where prescaler=CLK_DIV-1 and idx=DIGITS-1; otherwise 0.
- Disabled digits: still consume their full slot time, blanked. Scan timing is independent of digit_en and brightness.
- Arithmetic: the LIM product is computed at clog2(CLK_DIV)+1 bits with no overflow. Prescaler and index wrap exactly at their limits; no out-of-range index ever appears.

Test Plan:
Bench configuration: DIGITS=4, CLK_DIV=32, DEAD=2, unless stated otherwise.
- Reset then release; seg_data=0x00_3F_06_5B (digit0 = 0x5B), digit_en=4'b1111, brightness=15 -> an_n=4'b1111 during DEAD. an_n=4'b1110 and seg_n=0x5B for 30 cycles, then digit 1 (an_n=4'b1101, seg_n=0x06). Period 32 cycles per digit.
- Run 3 frames -> frame_tick high for exactly 1 cycle every 128 cycles, aligned with digit_idx returning 3->0. Never 2 bits of an_n low.
- brightness=3 -> each digit lit exactly 6 cycles per slot (p=2..7). brightness=0 -> an_n constant 4'b1111 and seg_n=0xFF.
- digit_en=4'b1010 -> digits 0 and 2 never drive an_n low. Slots still last 32 cycles; frame period unchanged at 128.
- Change seg_data digit1 from 0x06 to 0x4F at p=10 of slot 1 -> seg_n stays 0x06 through slot 1 and shows 0x4F from the next visit to slot 1.
- Assert reset for 1 cycle mid-slot 2 at p=15 -> next cycle an_n=4'b1111, seg_n=0xFF, digit_idx=0, frame_tick=0. Scan restarts from digit 0 with a full 32-cycle slot.
